// File: rtl/bus_arbiter16.sv
// bus_arbiter16: round-robin arbiter for one shared 16-bit datapath resource.
// Drives the one-hot grant vector and the 4-bit select of the downstream
// mux16_1. A grant is held until the owner signals done, drops its request,
// or (when HOLD_MAX != 0) has been held for HOLD_MAX cycles.
module bus_arbiter16 #(
  parameter int HOLD_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] I_REQ,
  input  logic        I_DONE,
  output logic [15:0] O_GNT,
  output logic [3:0]  O_SEL,
  output logic        O_VALID,
  output logic        O_TIMEOUT
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  localparam logic       HOLD_EN  = (HOLD_MAX != 0);

  state_t      state, state_d;
  logic [3:0]  ptr, ptr_d;
  logic [3:0]  sel_d;
  logic [7:0]  cnt, cnt_d;
  logic        timeout_d;

  logic [15:0] cand;
  logic [3:0]  idx;
  logic [3:0]  winner;
  logic        found;
  logic        owner_done;
  logic        owner_timeout;

  // Release reasons for the current owner; done/withdraw wins over timeout
  always_comb begin
    owner_done    = I_DONE || !I_REQ[O_SEL];
    owner_timeout = HOLD_EN && (cnt == HOLD_LIM) && !owner_done;
  end

  // Round-robin search: first pending request at or after ptr, wrapping mod 16.
  // The releasing owner is masked so it cannot win at its own release edge.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    cand   = I_REQ;
    idx    = 4'd0;
    winner = ptr;
    found  = 1'b0;
    if (state == GRANT) cand[O_SEL] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr + 4'(i);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state logic: new grant, release with back-to-back handoff, or hold
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    sel_d     = O_SEL;
    cnt_d     = cnt;
    timeout_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = winner;
          ptr_d   = winner + 4'd1;
          cnt_d   = 8'd1;
        end
      end
      GRANT: begin
        if (owner_done || owner_timeout) begin
          timeout_d = owner_timeout;
          if (found) begin
            sel_d = winner;
            ptr_d = winner + 4'd1;
            cnt_d = 8'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; all outputs come straight from flops
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state     <= IDLE;
      ptr       <= 4'd0;
      cnt       <= 8'd0;
      O_SEL     <= 4'd0;
      O_GNT     <= 16'h0000;
      O_TIMEOUT <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      O_SEL     <= sel_d;
      O_GNT     <= (state_d == GRANT) ? (16'h0001 << sel_d) : 16'h0000;
      O_TIMEOUT <= timeout_d;
    end
  end

  assign O_VALID = (state == GRANT);

endmodule

// File: tb/tb_bus_arbiter16.sv
// Testbench for bus_arbiter16: directed scenarios plus randomized traffic
// checked against a behavioural arbiter model. Two instances run in
// parallel on the same stimulus: HOLD_MAX=4 (index 0) and HOLD_MAX=0 (index 1).
module tb_bus_arbiter16;

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic        done;

  logic [15:0] gnt   [2];
  logic [3:0]  sel   [2];
  logic        valid [2];
  logic        tmo   [2];

  int n_checks;
  int n_fail;

  bus_arbiter16 #(.HOLD_MAX(4)) dut_h4 (
    .clk(clk), .reset(reset), .I_REQ(req), .I_DONE(done),
    .O_GNT(gnt[0]), .O_SEL(sel[0]), .O_VALID(valid[0]), .O_TIMEOUT(tmo[0])
  );

  bus_arbiter16 #(.HOLD_MAX(0)) dut_h0 (
    .clk(clk), .reset(reset), .I_REQ(req), .I_DONE(done),
    .O_GNT(gnt[1]), .O_SEL(sel[1]), .O_VALID(valid[1]), .O_TIMEOUT(tmo[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic       valid;
    logic [3:0] own;
    int         ptr;
    int         age;
    logic       to;
  } model_t;

  model_t mdl [2];

  function automatic int lim_of(int j);
    return (j == 0) ? 4 : 0;
  endfunction

  function automatic model_t model_clear();
    model_t s;
    s.valid = 1'b0;
    s.own   = 4'd0;
    s.ptr   = 0;
    s.age   = 0;
    s.to    = 1'b0;
    return s;
  endfunction

  // One clock of the arbitration rules, stated directly.
  function automatic model_t model_step(model_t s, logic [15:0] r, logic d, int lim);
    model_t n;
    bit     free_now;
    int     c;
    n        = s;
    n.to     = 1'b0;
    free_now = !s.valid;
    if (s.valid) begin
      if (d || !r[s.own]) free_now = 1'b1;
      else if (lim != 0 && s.age == lim) begin
        free_now = 1'b1;
        n.to     = 1'b1;
      end
    end
    if (free_now) begin
      n.valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
        c = (s.ptr + i) % 16;
        if (!n.valid && r[c] && !(s.valid && c == int'(s.own))) begin
          n.valid = 1'b1;
          n.own   = c[3:0];
          n.ptr   = (c + 1) % 16;
          n.age   = 1;
        end
      end
    end else begin
      n.age = s.age + 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int j = 0; j < 2; j++) begin
      if (reset) mdl[j] <= model_clear();
      else       mdl[j] <= model_step(mdl[j], req, done, lim_of(j));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 16'h0000;
    done  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 16'hFFFF;
    done  = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({gnt[j], sel[j], valid[j], tmo[j]} !== {16'h0, 4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_async dut%0d: gnt=%h sel=%0d valid=%b to=%b, expected all zero",
                 j, gnt[j], sel[j], valid[j], tmo[j]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    req   = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if ({gnt[j], sel[j], valid[j], tmo[j]} !== {16'h0, 4'd0, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL idle_hold dut%0d cyc%0d: gnt=%h sel=%0d valid=%b to=%b, expected all zero",
                   j, k, gnt[j], sel[j], valid[j], tmo[j]);
        end
      end
    end
  endtask

  task automatic test_single();
    req = 16'h0020;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({gnt[j], sel[j], valid[j], tmo[j]} !== {16'h0020, 4'd5, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL single_grant dut%0d: gnt=%h sel=%0d valid=%b, expected 0020/5/1",
                 j, gnt[j], sel[j], valid[j]);
      end
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 16'h0000;
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({gnt[j], sel[j], valid[j], tmo[j]} !== {16'h0000, 4'd5, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL single_release dut%0d: gnt=%h sel=%0d valid=%b, expected 0000/5/0",
                 j, gnt[j], sel[j], valid[j]);
      end
    end
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({valid[j], sel[j]} !== {1'b0, 4'd5}) begin
        n_fail++;
        $display("FAIL single_sel_hold dut%0d: sel=%0d valid=%b, expected 5/0", j, sel[j], valid[j]);
      end
    end
  endtask

  task automatic test_round_robin();
    int hits [16];
    do_reset();
    for (int i = 0; i < 16; i++) hits[i] = 0;
    req  = 16'hFFFF;
    done = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i < 16) hits[sel[0]]++;
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if ({gnt[j], sel[j], valid[j]} !== {16'h0001 << (i % 16), 4'(i % 16), 1'b1}) begin
          n_fail++;
          $display("FAIL rr_seq dut%0d step%0d: gnt=%h sel=%0d valid=%b, expected sel=%0d valid=1",
                   j, i, gnt[j], sel[j], valid[j], i % 16);
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (hits[i] != 1) begin
        n_fail++;
        $display("FAIL rr_fair idx%0d: granted %0d times, expected 1", i, hits[i]);
      end
    end
    req  = 16'h0000;
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap_mask();
    logic [3:0] exp_sel [3];
    exp_sel[0] = 4'd15;
    exp_sel[1] = 4'd0;
    exp_sel[2] = 4'd15;
    do_reset();
    req = 16'h4000;
    @(negedge clk);
    // owner 14 withdraws; pointer now sits at 15
    req = 16'h8001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      done = 1'b1;
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if ({sel[j], valid[j]} !== {exp_sel[k], 1'b1}) begin
          n_fail++;
          $display("FAIL wrap_mask dut%0d step%0d: sel=%0d valid=%b, expected %0d/1",
                   j, k, sel[j], valid[j], exp_sel[k]);
        end
      end
    end
    req  = 16'h0000;
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    req = 16'h0003;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k < 4) begin
        n_checks++;
        if ({gnt[0], sel[0], valid[0], tmo[0]} !== {16'h0001, 4'd0, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL to_hold cyc%0d: gnt=%h sel=%0d to=%b, expected 0001/0/0", k, gnt[0], sel[0], tmo[0]);
        end
      end else if (k == 4) begin
        n_checks++;
        if ({gnt[0], sel[0], valid[0], tmo[0]} !== {16'h0002, 4'd1, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL to_fire: gnt=%h sel=%0d to=%b, expected 0002/1/1", gnt[0], sel[0], tmo[0]);
        end
      end else if (k == 5) begin
        n_checks++;
        if ({sel[0], valid[0], tmo[0]} !== {4'd1, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL to_pulse: sel=%0d to=%b, expected 1/0", sel[0], tmo[0]);
        end
      end
      n_checks++;
      if ({gnt[1], sel[1], valid[1], tmo[1]} !== {16'h0001, 4'd0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL unlimited_hold cyc%0d: gnt=%h sel=%0d to=%b, expected 0001/0/0",
                 k, gnt[1], sel[1], tmo[1]);
      end
    end
    req = 16'h0000;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 16'h0080;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({gnt[j], sel[j], valid[j]} !== {16'h0080, 4'd7, 1'b1}) begin
        n_fail++;
        $display("FAIL areset_pre dut%0d: gnt=%h sel=%0d valid=%b, expected 0080/7/1",
                 j, gnt[j], sel[j], valid[j]);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({gnt[j], sel[j], valid[j], tmo[j]} !== {16'h0, 4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL areset_drop dut%0d: gnt=%h sel=%0d valid=%b to=%b, expected all zero",
                 j, gnt[j], sel[j], valid[j], tmo[j]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({gnt[j], sel[j], valid[j], tmo[j]} !== {16'h0080, 4'd7, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL areset_regrant dut%0d: gnt=%h sel=%0d valid=%b, expected 0080/7/1",
                 j, gnt[j], sel[j], valid[j]);
      end
    end
    req = 16'h0000;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] exp_gnt;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        exp_gnt = mdl[j].valid ? (16'h0001 << mdl[j].own) : 16'h0000;
        n_checks++;
        if ({gnt[j], sel[j], valid[j], tmo[j]} !== {exp_gnt, mdl[j].own, mdl[j].valid, mdl[j].to}) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: gnt=%h sel=%0d valid=%b to=%b, expected %h/%0d/%b/%b",
                   j, k, gnt[j], sel[j], valid[j], tmo[j],
                   exp_gnt, mdl[j].own, mdl[j].valid, mdl[j].to);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       req = 16'h0000;
          1:       req = 16'($urandom);
          default: req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        endcase
      end
      done = ($urandom_range(0, 4) == 0);
    end
    req  = 16'h0000;
    done = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    req      = 16'h0000;
    done     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_mask();
    test_timeout();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter16.md
# bus_arbiter16

Round-robin arbiter that shares one 16-bit datapath resource among up to 16 requesters. It drives the 4-bit select of the 16:1 operand/bus mux (`mux16_1`) and a one-hot grant vector. Grants are registered and held until the owner signals completion, drops its request, or exceeds a hold limit. It sits between the requesting units and the shared mux.

## Interface
- HOLD_MAX, 16, maximum cycles a grant may be held before forced release; 0 = unlimited; legal range 0–255
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- I_REQ  input  16  request vector, bit k = requester k wants the resource; level, held until granted and done
- I_DONE  input  1  current owner finished; valid only while O_VALID=1
- O_GNT  output  16  one-hot grant, all-zero when idle
- O_SEL  output  4  index of current/last owner, wired to `mux16_1` select
- O_VALID  output  1  a grant is active
- O_TIMEOUT  output  1  one-cycle pulse: the previous grant was force-released by HOLD_MAX

## Operation
- States: IDLE (O_VALID=0), GRANT (O_VALID=1).
- Priority pointer `ptr[3:0]`: search order ptr, ptr+1, …, ptr+15, mod 16. After granting index k, ptr ← k+1 mod 16 (15 wraps to 0).
- IDLE: if I_REQ≠0, grant the first set bit in search order → GRANT. Otherwise stay.
- GRANT, owner k. A release occurs on the first of:
  - I_DONE=1;
  - I_REQ[k]=0 (request withdrawn, treated as done);
  - hold counter reaches HOLD_MAX, with HOLD_MAX≠0 → O_TIMEOUT=1 on the following cycle.
- On the release edge, arbitrate among I_REQ with bit k masked, starting from the updated ptr:
  - some request pending → grant it directly (back-to-back, no idle cycle), stay in GRANT;
  - none → IDLE.
- Owner k is never regranted at its own release edge, even if I_REQ[k] stays high. It may win again one cycle later.
- Hold counter: 8-bit, cleared to 1 on every new grant, increments each cycle in GRANT. Release when counter == HOLD_MAX at the edge, so a grant lasts at most HOLD_MAX cycles.
- O_SEL updates only on a new grant. In IDLE it keeps the last owner so the mux output stays stable.
- Invariant: O_GNT == (O_VALID ? 1<<O_SEL : 0).

## Timing
- Reset (async, immediate): state=IDLE, O_GNT=0, O_SEL=0, O_VALID=0, O_TIMEOUT=0, ptr=0, counter=0.
- Reset asserted mid-grant: grant drops immediately, with no O_TIMEOUT. After deassertion, behaviour matches post-reset.
- Latency: I_REQ sampled at edge t → O_GNT/O_SEL/O_VALID valid after edge t (registered outputs, 1 cycle from request visible).
- Release plus next grant happen at the same edge. Owner change is visible on the cycle after I_DONE is sampled.
- Simultaneous I_DONE and timeout: treated as a normal done, O_TIMEOUT=0.
- I_DONE while IDLE: ignored.
- All outputs registered. No combinational path from inputs to outputs.

## Test plan
- Reset/idle: reset=1 with I_REQ=16'hFFFF → O_GNT=0, O_SEL=0, O_VALID=0; release reset, I_REQ=0 for 5 cycles → outputs unchanged.
- Single requester: I_REQ=16'h0020 → next edge O_GNT=16'h0020, O_SEL=5, O_VALID=1. Pulse I_DONE, drop request → O_VALID=0, O_SEL stays 5.
- Round-robin fairness: I_REQ=16'hFFFF, I_DONE=1 every cycle → O_SEL sequence 0,1,2,…,15,0. Each index is granted once per 16 grants. Back-to-back, O_VALID never drops.
- Wrap and mask: ptr at 15, I_REQ=16'h8001, grant 15, I_DONE → next owner 0 (not 15). Then I_DONE → owner 15.
- Timeout: HOLD_MAX=4, I_REQ=16'h0003, no I_DONE → owner 0 for 4 cycles, then owner 1 with O_TIMEOUT=1 for exactly one cycle. Also check HOLD_MAX=0 holds owner 0 for 300 cycles.
- Async reset mid-grant: owner 7 active, assert reset between edges → O_GNT=0, O_VALID=0 before next edge. After release, I_REQ=16'h0080 → regrant 7 after one edge.
